// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: bit-serial add/subtract engine, LSB first.
//
// One full adder/subtractor slice is reused for WIDTH clocks. The carry
// lives in a flip-flop between bits, and each sum bit enters a shift
// register from the MSB end. The visible result and flags are loaded
// only when the last bit completes, so they hold steady while the next
// operation runs.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high; clears all state
//   start      request pulse, accepted only in IDLE
//   subtr      0 = a+b, 1 = a-b (latched with the operands)
//   a, b       WIDTH-bit operands, latched when start is accepted
//   busy       high while bits are being processed
//   done       one-cycle pulse when result/flags become valid
//   result     a+b or a-b mod 2^WIDTH
//   carry_out  carry out of the MSB slice (1 = no borrow when subtracting)
//   overflow   signed overflow
//   zero       result == 0
//   negative   result[WIDTH-1]

// Single-bit full adder/subtractor slice. B is inverted when subtracting;
// the +1 of the two's complement comes in through the initial carry.
module serial_addsub_cell (
    input  logic a,
    input  logic b,
    input  logic subtr,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic bx;

    assign bx   = b ^ subtr;
    assign sum  = a ^ bx ^ cin;
    assign cout = (a & bx) | (a & cin) | (bx & cin);
endmodule

module serial_addsub_unit #(
    parameter int WIDTH = 64,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             subtr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sub_q;
    logic             c_q;
    logic [WIDTH-1:0] sr;

    logic             sum_bit, cout_bit;
    logic [WIDTH-1:0] sr_nxt;

    serial_addsub_cell u_cell (
        .a     (a_q[cnt]),
        .b     (b_q[cnt]),
        .subtr (sub_q),
        .cin   (c_q),
        .sum   (sum_bit),
        .cout  (cout_bit)
    );

    // New bit enters at the top; after WIDTH shifts bit 0 lands at sr[0].
    assign sr_nxt = {sum_bit, sr[WIDTH-1:1]};

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            c_q       <= 1'b0;
            sr        <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= subtr;
                        c_q   <= subtr;   // +1 of two's complement
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sr  <= sr_nxt;
                    c_q <= cout_bit;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result    <= sr_nxt;
                        carry_out <= cout_bit;
                        // c_q is still the carry into the MSB slice here
                        overflow  <= c_q ^ cout_bit;
                        zero      <= ~|sr_nxt;
                        negative  <= sr_nxt[WIDTH-1];
                        state     <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub_unit.sv
`timescale 1ps/1ps
module tb_serial_addsub_unit;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset, start, subtr;
    logic [WIDTH-1:0] a, b, result;
    logic             busy, done, carry_out, overflow, zero, negative;

    int               checks   = 0;
    int               failures = 0;
    logic [WIDTH-1:0] prev_res;

    always #500 clk = ~clk;

    serial_addsub_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .subtr     (subtr),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation and check latency, busy span, result, flags and
    // that the previous result is held during RUN. With disturb set, a
    // second start with different operands is pulsed at RUN cycle 3.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vs, input logic [WIDTH-1:0] er, input logic eco,
                          input logic eov, input logic ezr, input logic eng, input bit disturb);
        int cyc, nbusy, extra;
        bit seen;
        @(negedge clk);
        a = va; b = vb; subtr = vs; start = 1'b1;
        cyc = 0; nbusy = 0; seen = 0;
        while (!seen && cyc < WIDTH + 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (disturb && cyc == 3) begin
                start = 1'b1; a = 8'hFF; b = ~vb; subtr = ~vs;
            end
            if (disturb && cyc == 4) start = 1'b0;
            if (busy) nbusy++;
            if (cyc == 2) chk({tag, ".hold"}, result, prev_res);
            if (done) seen = 1;
        end
        chk({tag, ".lat"}, cyc, WIDTH + 1);
        chk({tag, ".busycyc"}, nbusy, WIDTH);
        chk({tag, ".res"}, result, er);
        chk({tag, ".co"}, carry_out, eco);
        chk({tag, ".ov"}, overflow, eov);
        chk({tag, ".zr"}, zero, ezr);
        chk({tag, ".ng"}, negative, eng);
        @(negedge clk);
        chk({tag, ".pulse"}, {busy, done}, 2'b00);
        if (disturb) begin
            extra = 0;
            repeat (WIDTH + 2) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk({tag, ".nodone"}, extra, 0);
            chk({tag, ".keep"}, result, er);
        end
        prev_res = er;
    endtask

    initial begin
        int extra;
        reset = 1'b1; start = 1'b0; subtr = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.res", result, 0);
        chk("rst.flags", {carry_out, overflow, zero, negative}, 4'b0000);
        prev_res = '0;

        //      tag    a      b      sub   result co ov zr ng dist
        run_op("add1", 8'h05, 8'h03, 1'b0, 8'h08, 0, 0, 0, 0, 0);
        run_op("sub1", 8'h03, 8'h05, 1'b1, 8'hFE, 0, 0, 0, 1, 0);
        run_op("ovfa", 8'h7F, 8'h01, 1'b0, 8'h80, 0, 1, 0, 1, 0);
        run_op("ovfs", 8'h80, 8'h01, 1'b1, 8'h7F, 1, 1, 0, 0, 0);
        run_op("z00",  8'h00, 8'h00, 1'b1, 8'h00, 1, 0, 1, 0, 0);
        run_op("zsub", 8'h5A, 8'h5A, 1'b1, 8'h00, 1, 0, 1, 0, 0);
        run_op("zadd", 8'hFF, 8'h01, 1'b0, 8'h00, 1, 0, 1, 0, 0);
        run_op("dist", 8'h10, 8'h20, 1'b0, 8'h30, 0, 0, 0, 0, 1);

        // Abort with reset at RUN cycle 4
        @(negedge clk);
        a = 8'h0F; b = 8'h01; subtr = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.res", result, 0);
        chk("abort.flags", {carry_out, overflow, zero, negative}, 4'b0000);
        extra = 0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("abort.nodone", extra, 0);
        prev_res = '0;
        run_op("fresh", 8'h0F, 8'h01, 1'b0, 8'h10, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
